vend_event_sequencer: RTL and testbench

//  Front-end controller for the vending datapath on the DE1 board.
//  - Synchronises and debounces the KEY1 pushbutton.
//  - Samples the coin/credit/clear switches once per press and classifies them into one event code.
//  - Hands each event to the vending core over a valid/ready handshake.
//  - The core never touches raw keys or switches and never sees a bounce.

---
 rtl/vend_event_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_vend_event_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/vend_event_sequencer.sv
// Purpose : debounce KEY1, sample coin/credit/clear switches once per press, offer one event code per press.
// Latency : ev_valid rises DEBOUNCE_CYCLES+3 edges after key_n is first sampled low (clean press).
// Backpres: ev_valid/ev_code held until ev_ready; key release and switch changes while offering are ignored.
//
// Ports: clock, reset_n (async assert, synchronised release), key_n (raw KEY1, active-low),
//        sw_coin[5:0] {clear, credit, dollar, quarter, dime, nickel}, report_mode (raw sw9),
//        ev_valid/ev_code[3:0]/ev_ready (event handshake), busy (not IDLE),
//        ev_count[7:0] (accepted events, wrapping), ev_drop (press discarded in report mode).
// Optional: define VEND_CONSEC_CHECK_EN to flag DOLLAR-DOLLAR / CREDIT-CREDIT as CONSEC_ERR (code 8).
module vend_event_sequencer #(
   parameter int DEBOUNCE_CYCLES = 240000,
   parameter int CNT_W           = 18
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       key_n,
   input  logic [5:0] sw_coin,
   input  logic       report_mode,
   output logic       ev_valid,
   output logic [3:0] ev_code,
   input  logic       ev_ready,
   output logic       busy,
   output logic [7:0] ev_count,
   output logic       ev_drop
);

   localparam logic [3:0] C_DOLLAR = 4'd4;
   localparam logic [3:0] C_CREDIT = 4'd5;
   localparam logic [3:0] C_MULTI  = 4'd7;
`ifdef VEND_CONSEC_CHECK_EN
   localparam logic [3:0] C_CONSEC = 4'd8;
`endif

   // Press is confirmed on the edge where the counter would reach DEBOUNCE_CYCLES-1,
   // so the synced key has been low for DEBOUNCE_CYCLES samples (IDLE sample included).
   localparam logic [CNT_W-1:0] PRS_LAST = (DEBOUNCE_CYCLES > 1) ? CNT_W'(DEBOUNCE_CYCLES - 2) : '0;
   localparam logic [CNT_W-1:0] REL_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {S_IDLE, S_DEB_PRS, S_CAPTURE, S_OFFER, S_DEB_REL} state_e;

   // reset synchroniser: all other flops use the synchronised release
   logic rst_s1_q, rst_s1_d, rst_s2_q, rst_s2_d;
   logic rst_n;

   logic       key_s1_q, key_s1_d, key_s2_q, key_s2_d;
   logic [5:0] sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
   logic       rep_s1_q, rep_s1_d, rep_s2_q, rep_s2_d;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ev_valid_q, ev_valid_d;
   logic [3:0]       ev_code_q, ev_code_d;
   logic [7:0]       ev_count_q, ev_count_d;
   logic             ev_drop_q, ev_drop_d;
   logic [3:0]       cls;

`ifdef VEND_CONSEC_CHECK_EN
   typedef enum logic [1:0] {TRK_NONE, TRK_DOLLAR, TRK_CREDIT} trk_e;
   trk_e trk_q, trk_d;
`endif

   // 0 bits -> ADVANCE, 1 bit -> index+1, more -> MULTI_ERR
   function automatic logic [3:0] classify(input logic [5:0] sw);
      logic [3:0] code;
      int         ones;
      code = 4'd0;
      ones = 0;
      for (int i = 0; i < 6; i++) begin
         if (sw[i]) begin
            ones = ones + 1;
            code = 4'(i + 1);
         end
      end
      if (ones > 1) code = C_MULTI;
      return code;
   endfunction

   always_comb begin
      rst_s1_d = 1'b1;
      rst_s2_d = rst_s1_q;
      key_s1_d = key_n;
      key_s2_d = key_s1_q;
      sw_s1_d  = sw_coin;
      sw_s2_d  = sw_s1_q;
      rep_s1_d = report_mode;
      rep_s2_d = rep_s1_q;
   end

   assign rst_n = rst_s2_q;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rst_s1_q <= 1'b0;
         rst_s2_q <= 1'b0;
      end else begin
         rst_s1_q <= rst_s1_d;
         rst_s2_q <= rst_s2_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ev_valid_d = ev_valid_q;
      ev_code_d  = ev_code_q;
      ev_count_d = ev_count_q;
      ev_drop_d  = 1'b0;
      cls        = classify(sw_s2_q);
`ifdef VEND_CONSEC_CHECK_EN
      trk_d      = trk_q;
      if ((cls == C_DOLLAR && trk_q == TRK_DOLLAR) || (cls == C_CREDIT && trk_q == TRK_CREDIT))
         cls = C_CONSEC;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (!key_s2_q) begin
               state_d = S_DEB_PRS;
               cnt_d   = '0;
            end
         end
         S_DEB_PRS: begin
            if (key_s2_q) begin
               state_d = S_IDLE;
            end else if (cnt_q >= PRS_LAST) begin
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_CAPTURE: begin
            cnt_d = '0;
            if (rep_s2_q) begin
               ev_drop_d = 1'b1;
               state_d   = S_DEB_REL;
            end else begin
               ev_code_d  = cls;
               ev_valid_d = 1'b1;
               state_d    = S_OFFER;
            end
         end
         S_OFFER: begin
            if (ev_ready) begin
               ev_valid_d = 1'b0;
               ev_count_d = ev_count_q + 8'd1;
               cnt_d      = '0;
               state_d    = S_DEB_REL;
`ifdef VEND_CONSEC_CHECK_EN
               if (ev_code_q == C_DOLLAR)      trk_d = TRK_DOLLAR;
               else if (ev_code_q == C_CREDIT) trk_d = TRK_CREDIT;
               else                            trk_d = TRK_NONE;
`endif
            end
         end
         S_DEB_REL: begin
            // any low sample restarts the release window
            if (!key_s2_q)              cnt_d = '0;
            else if (cnt_q >= REL_LAST) state_d = S_IDLE;
            else                        cnt_d = cnt_q + 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         key_s1_q   <= 1'b1;
         key_s2_q   <= 1'b1;
         sw_s1_q    <= '0;
         sw_s2_q    <= '0;
         rep_s1_q   <= 1'b0;
         rep_s2_q   <= 1'b0;
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ev_valid_q <= 1'b0;
         ev_code_q  <= '0;
         ev_count_q <= '0;
         ev_drop_q  <= 1'b0;
`ifdef VEND_CONSEC_CHECK_EN
         trk_q      <= TRK_NONE;
`endif
      end else begin
         key_s1_q   <= key_s1_d;
         key_s2_q   <= key_s2_d;
         sw_s1_q    <= sw_s1_d;
         sw_s2_q    <= sw_s2_d;
         rep_s1_q   <= rep_s1_d;
         rep_s2_q   <= rep_s2_d;
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ev_valid_q <= ev_valid_d;
         ev_code_q  <= ev_code_d;
         ev_count_q <= ev_count_d;
         ev_drop_q  <= ev_drop_d;
`ifdef VEND_CONSEC_CHECK_EN
         trk_q      <= trk_d;
`endif
      end
   end

   assign ev_valid = ev_valid_q;
   assign ev_code  = ev_code_q;
   assign ev_count = ev_count_q;
   assign ev_drop  = ev_drop_q;
   assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_vend_event_sequencer.sv
// Purpose : directed bench for vend_event_sequencer with DEBOUNCE_CYCLES=4.
// Latency : expected event codes queued at press time, compared when the handshake completes.
// Backpres: ev_ready normally 1; one step stalls it to check the offer holds.
module tb_vend_event_sequencer;

   logic       clock;
   logic       reset_n;
   logic       key_n;
   logic [5:0] sw_coin;
   logic       report_mode;
   logic       ev_valid;
   logic [3:0] ev_code;
   logic       ev_ready;
   logic       busy;
   logic [7:0] ev_count;
   logic       ev_drop;

   int checks = 0;
   int errors = 0;
   int seen   = 0;
   int exp_cnt = 0;
   logic [3:0] exp_q[$];

   vend_event_sequencer #(.DEBOUNCE_CYCLES(4), .CNT_W(18)) dut (
      .clock(clock), .reset_n(reset_n), .key_n(key_n), .sw_coin(sw_coin),
      .report_mode(report_mode), .ev_valid(ev_valid), .ev_code(ev_code),
      .ev_ready(ev_ready), .busy(busy), .ev_count(ev_count), .ev_drop(ev_drop)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not end, observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // scoreboard: every completed handshake must match the oldest queued code
   always @(negedge clock) begin
      if (reset_n && ev_valid && ev_ready) begin
         checks++;
         assert (exp_q.size() > 0) else begin
            errors++;
            $error("FAIL unexpected_event observed=code%0d expected=no_event", ev_code);
         end
         if (exp_q.size() > 0) chk("ev_code", 32'(ev_code), 32'(exp_q.pop_front()));
         seen++;
      end
   end

   task automatic wait_valid(input int budget, output int n);
      n = 0;
      while (!ev_valid && n < budget) begin
         tick(1);
         n++;
      end
      chk("valid_within_budget", 32'(ev_valid), 32'd1);
   endtask

   task automatic press(input logic [5:0] sw, input logic rep, output int valids, output int drops);
      sw_coin = sw;
      report_mode = rep;
      key_n = 1'b0;
      valids = 0;
      drops = 0;
      repeat (14) begin
         tick(1);
         if (ev_valid) valids++;
         if (ev_drop) drops++;
      end
      key_n = 1'b1;
      repeat (12) begin
         tick(1);
         if (ev_valid) valids++;
         if (ev_drop) drops++;
      end
      report_mode = 1'b0;
   endtask

   initial begin
      int n, v, d;
      key_n = 1'b1;
      sw_coin = '0;
      report_mode = 1'b0;
      ev_ready = 1'b1;
      reset_n = 1'b0;
      tick(3);
      chk("rst_ev_valid", 32'(ev_valid), 32'd0);
      chk("rst_ev_code", 32'(ev_code), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ev_count", 32'(ev_count), 32'd0);
      chk("rst_ev_drop", 32'(ev_drop), 32'd0);
      reset_n = 1'b1;
      tick(4);

      // 1: quarter, clean press, latency DEBOUNCE+3 = 7 edges
      sw_coin = 6'b000100;
      exp_q.push_back(4'd3);
      exp_cnt++;
      key_n = 1'b0;
      wait_valid(20, n);
      chk("t1_latency", 32'(n), 32'd7);
      chk("t1_busy", 32'(busy), 32'd1);
      chk("t1_count_before_accept", 32'(ev_count), 32'd0);
      tick(1);
      chk("t1_valid_one_cycle", 32'(ev_valid), 32'd0);
      chk("t1_count", 32'(ev_count), 32'(exp_cnt));
      key_n = 1'b1;
      tick(12);
      chk("t1_idle", 32'(busy), 32'd0);

      // 2: bounce then hold -> one nickel event
      key_n = 1'b0; tick(2);
      key_n = 1'b1; tick(2);
      exp_q.push_back(4'd1);
      exp_cnt++;
      press(6'b000001, 1'b0, v, d);
      chk("t2_one_event", 32'(v), 32'd1);
      chk("t2_count", 32'(ev_count), 32'(exp_cnt));

      // 3: classification
      exp_q.push_back(4'd7); exp_cnt++;
      press(6'b001010, 1'b0, v, d);
      chk("t3_multi_valid", 32'(v), 32'd1);
      exp_q.push_back(4'd0); exp_cnt++;
      press(6'b000000, 1'b0, v, d);
      chk("t3_advance_valid", 32'(v), 32'd1);
      exp_q.push_back(4'd6); exp_cnt++;
      press(6'b100000, 1'b0, v, d);
      chk("t3_clear_valid", 32'(v), 32'd1);
      chk("t3_count", 32'(ev_count), 32'(exp_cnt));

      // 4: stall, release key and change switches while offering
      ev_ready = 1'b0;
      sw_coin = 6'b000010;
      exp_q.push_back(4'd2);
      exp_cnt++;
      key_n = 1'b0;
      wait_valid(20, n);
      key_n = 1'b1;
      sw_coin = 6'b111111;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("t4_hold_valid", 32'(ev_valid), 32'd1);
         chk("t4_hold_code", 32'(ev_code), 32'd2);
      end
      ev_ready = 1'b1;
      tick(1);
      chk("t4_accepted", 32'(ev_valid), 32'd0);
      chk("t4_count", 32'(ev_count), 32'(exp_cnt));
      sw_coin = 6'b000000;
      tick(12);

      // 5: report mode discards the press
      press(6'b000100, 1'b1, v, d);
      chk("t5_drop_pulses", 32'(d), 32'd1);
      chk("t5_no_valid", 32'(v), 32'd0);
      chk("t5_count", 32'(ev_count), 32'(exp_cnt));

      // 6: consecutive dollars
      exp_q.push_back(4'd4);
`ifdef VEND_CONSEC_CHECK_EN
      exp_q.push_back(4'd8);
`else
      exp_q.push_back(4'd4);
`endif
      exp_q.push_back(4'd4);
      exp_cnt += 3;
      for (int i = 0; i < 3; i++) begin
         press(6'b001000, 1'b0, v, d);
         chk("t6_dollar_valid", 32'(v), 32'd1);
      end
      chk("t6_count", 32'(ev_count), 32'(exp_cnt));

      // reset while offering: output clears at once, next press starts fresh
      ev_ready = 1'b0;
      sw_coin = 6'b001000;
      key_n = 1'b0;
      wait_valid(20, n);
      reset_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(ev_valid), 32'd0);
      chk("t6_rst_count", 32'(ev_count), 32'd0);
      chk("t6_rst_busy", 32'(busy), 32'd0);
      key_n = 1'b1;
      ev_ready = 1'b1;
      tick(3);
      reset_n = 1'b1;
      tick(5);
      exp_cnt = 1;
      exp_q.push_back(4'd4);
      press(6'b001000, 1'b0, v, d);
      chk("t6_after_rst_valid", 32'(v), 32'd1);
      chk("t6_after_rst_count", 32'(ev_count), 32'(exp_cnt));

      chk("events_seen", 32'(seen), 32'd10);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
